// File: rtl/xor_64_pkg.sv
// xor_64_pkg: shared width constant and signed word type for the xor_64 datapath
package xor_64_pkg;
    localparam int WIDTH_DEF = 64;
    typedef logic signed [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/xor_64_if.sv
// xor_64_if: operand/result bundle for xor_64 (a, b, in_valid in; ans, out_valid, zf, sf out)
interface xor_64_if;
    import xor_64_pkg::*;
    word_t a;
    word_t b;
    logic  in_valid;
    word_t ans;
    logic  out_valid;
    logic  zf;
    logic  sf;
    modport master (output a, b, in_valid, input ans, out_valid, zf, sf);
    modport slave  (input a, b, in_valid, output ans, out_valid, zf, sf);
endinterface

// File: rtl/xor_64_xor_1.sv
// xor_1: single-bit XOR cell (a, b in; y out)
module xor_1 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/xor_64.sv
// xor_64: registered bitwise XOR with zero/sign flags and a one-cycle valid pipeline
// ports: ans (result), a/b (operands), clk, rst_n (sync active-low), in_valid, out_valid, zf, sf
module xor_64
    import xor_64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    output logic signed [WIDTH-1:0] ans,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    out_valid,
    output logic                    zf,
    output logic                    sf
);
    logic [WIDTH-1:0] x;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            xor_1 u_cell (.a(a[i]), .b(b[i]), .y(x[i]));
        end
    endgenerate
    // flags are derived from the combinational vector so they land with ans
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ans       <= '0;
            zf        <= 1'b1;
            sf        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ans <= x;
                zf  <= ~|x;
                sf  <= x[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_xor_64.sv
// tb_xor_64: directed self-checking bench for xor_64
module tb_xor_64;
    import xor_64_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    xor_64_if bus ();
    xor_64 dut (
        .ans(bus.ans), .a(bus.a), .b(bus.b), .clk(clk), .rst_n(rst_n),
        .in_valid(bus.in_valid), .out_valid(bus.out_valid), .zf(bus.zf), .sf(bus.sf)
    );
    always #5 clk = ~clk;
    localparam word_t BA = 64'sd100000000000000000;
    localparam word_t BB = 64'sd110101010101010101;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input word_t a, input word_t b, input logic v);
        bus.a = a;
        bus.b = b;
        bus.in_valid = v;
    endtask
    task automatic chk_res(input string tag, input word_t exp);
        chk({tag, ".ans"}, bus.ans, exp);
        chk({tag, ".zf"}, 64'(bus.zf), 64'(exp == 0));
        chk({tag, ".sf"}, 64'(bus.sf), 64'(exp[63]));
        chk({tag, ".ov"}, 64'(bus.out_valid), 64'd1);
    endtask
    word_t va[4];
    word_t vb[4];
    initial begin
        drive(0, 0, 1'b0);
        cycle();
        cycle();
        chk("rst.ans", bus.ans, 64'd0);
        chk("rst.zf", 64'(bus.zf), 64'd1);
        chk("rst.sf", 64'(bus.sf), 64'd0);
        chk("rst.ov", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        drive(20, 50, 1'b1);
        cycle();
        chk_res("pp", 64'sd38);
        drive(-20, 50, 1'b1);
        cycle();
        chk_res("np", -64'sd34);
        drive(20, -50, 1'b1);
        cycle();
        chk_res("pn", -64'sd38);
        drive(-20, -50, 1'b1);
        cycle();
        chk_res("nn", 64'sd34);
        va = '{BA, -BA, BA, -BA};
        vb = '{BB, BB, -BB, -BB};
        for (int k = 0; k < 4; k++) begin
            drive(va[k], vb[k], 1'b1);
            cycle();
            chk_res($sformatf("big%0d", k), va[k] ^ vb[k]);
        end
        drive(64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A, 1'b1);
        cycle();
        chk_res("eq", 64'd0);
        drive(-64'sd1, 0, 1'b1);
        cycle();
        chk_res("ones", -64'sd1);
        drive(20, 50, 1'b1);
        cycle();
        chk_res("load", 64'sd38);
        for (int k = 0; k < 3; k++) begin
            drive(word_t'(k * 7 + 3), word_t'(-k - 9), 1'b0);
            cycle();
            chk($sformatf("hold%0d.ans", k), bus.ans, 64'sd38);
            chk($sformatf("hold%0d.zf", k), 64'(bus.zf), 64'd0);
            chk($sformatf("hold%0d.ov", k), 64'(bus.out_valid), 64'd0);
        end
        rst_n = 1'b0;
        drive(20, 50, 1'b1);
        cycle();
        chk("rstv.ans", bus.ans, 64'd0);
        chk("rstv.zf", 64'(bus.zf), 64'd1);
        chk("rstv.ov", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        drive(-20, 50, 1'b1);
        cycle();
        chk_res("post", -64'sd34);
        drive(0, 0, 1'b0);
        cycle();
        chk("idle.ov", 64'(bus.out_valid), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
